// File: rtl/sysbus_arb_pkg.sv
// -----------------------------------------------------------------------------
// sysbus_arb_pkg
// Shared types and constants for the two-requester Sysbus line-read arbiter.
//   - state_e   : arbiter FSM states (IDLE, REQ, RESP, DONE)
//   - req_id_e  : requester identity, also the low byte of the bus tag
//   - LINE_BEATS / LINE_BITS : cache line geometry
//   - TAG_CMD   : upper tag bits {SYSBUS_READ, SYSBUS_MEMORY} of a line read
// The Sysbus command macros get local fallbacks when no system-level
// definition is present.
// -----------------------------------------------------------------------------
`ifndef SYSBUS_READ
`define SYSBUS_READ 2'b01
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 3'b001
`endif

package sysbus_arb_pkg;

    localparam int LINE_BEATS = 8;
    localparam int LINE_BITS  = 512;

    localparam logic [4:0] TAG_CMD = {`SYSBUS_READ, `SYSBUS_MEMORY};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        ID_IF = 1'b0,
        ID_DM = 1'b1
    } req_id_e;

endpackage

// File: rtl/sysbus_line_assembler.sv
// -----------------------------------------------------------------------------
// sysbus_line_assembler
// Collects the response beats of one line read into a line register.
// A beat is stored only while the arbiter is collecting (i_active), the bus
// presents a beat (i_respcyc) and the tag low byte equals the owner id.
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   i_clear        : restart the beat counter for a new transfer
//   i_active       : arbiter is in its response-collection state
//   i_respcyc      : response beat valid on the bus
//   i_tag_lo       : low byte of the response tag
//   i_resp         : response beat data
//   i_id           : id of the transaction owner
//   o_last         : the beat stored this cycle completes the line
//   o_line         : assembled line
// -----------------------------------------------------------------------------
module sysbus_line_assembler #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int LINE_BEATS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_clear,
    input  logic                                 i_active,
    input  logic                                 i_respcyc,
    input  logic [7:0]                           i_tag_lo,
    input  logic [BUS_DATA_WIDTH-1:0]            i_resp,
    input  sysbus_arb_pkg::req_id_e              i_id,
    output logic                                 o_last,
    output logic [LINE_BEATS*BUS_DATA_WIDTH-1:0] o_line
);

    localparam int CW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    logic [CW-1:0]                          r_count;
    logic [LINE_BEATS*BUS_DATA_WIDTH-1:0]   r_line;
    logic                                   w_store;

    // Beat acceptance and end-of-line detection
    always_comb begin
        w_store = i_active && i_respcyc && (i_tag_lo == 8'(i_id));
        o_last  = w_store && (r_count == CW'(LINE_BEATS - 1));
    end

    // Beat counter and line storage; the counter wraps only on the last beat
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_line  <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_store) begin
            r_line[r_count*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= i_resp;
            if (o_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/sysbus_arbiter.sv
// -----------------------------------------------------------------------------
// sysbus_arbiter
// Arbitrates line reads from a fetch (IF) and a data-memory (DM) requester
// onto one Sysbus master port, one transaction at a time.
// Ports:
//   clk, reset                     : clock, synchronous active-low reset
//   if_req/if_addr/if_gnt/if_done  : fetch requester handshake
//   dm_req/dm_addr/dm_gnt/dm_done  : data-memory requester handshake
//   line_out                       : assembled line, valid with if_done/dm_done
//   bus_reqcyc/bus_req/bus_reqtag/bus_reqack : Sysbus request channel
//   bus_respcyc/bus_resp/bus_resptag/bus_respack : Sysbus response channel
// Configuration:
//   SYSBUS_ARB_ROUND_ROBIN_EN defined   -> simultaneous requests alternate,
//                                          the requester not served last wins
//   SYSBUS_ARB_ROUND_ROBIN_EN undefined -> DM always beats IF
// -----------------------------------------------------------------------------
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 if_req,
    input  logic [63:0]                          if_addr,
    output logic                                 if_gnt,
    output logic                                 if_done,
    input  logic                                 dm_req,
    input  logic [63:0]                          dm_addr,
    output logic                                 dm_gnt,
    output logic                                 dm_done,
    output logic [LINE_BEATS*BUS_DATA_WIDTH-1:0] line_out,
    output logic                                 bus_reqcyc,
    output logic [63:0]                          bus_req,
    output logic [BUS_TAG_WIDTH-1:0]             bus_reqtag,
    output logic                                 bus_respack,
    input  logic                                 bus_reqack,
    input  logic                                 bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]            bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]             bus_resptag
);

    import sysbus_arb_pkg::*;

    localparam int OFFS_W = $clog2((LINE_BEATS * BUS_DATA_WIDTH) / 8);

    state_e         r_state;
    req_id_e        r_owner;
    req_id_e        w_winner;
    logic           w_any_req;
    logic [63:0]    w_line_addr;
    logic           w_last;
    logic           w_unused_bits;
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
    req_id_e        r_last_served;
`endif

    // Winner selection among the currently raised requests
    always_comb begin
        w_any_req = if_req | dm_req;
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
        if (if_req && dm_req) begin
            w_winner = (r_last_served == ID_IF) ? ID_DM : ID_IF;
        end else if (dm_req) begin
            w_winner = ID_DM;
        end else begin
            w_winner = ID_IF;
        end
`else
        if (dm_req) begin
            w_winner = ID_DM;
        end else begin
            w_winner = ID_IF;
        end
`endif
        if (w_winner == ID_DM) begin
            w_line_addr = {dm_addr[63:OFFS_W], {OFFS_W{1'b0}}};
        end else begin
            w_line_addr = {if_addr[63:OFFS_W], {OFFS_W{1'b0}}};
        end
    end

    // Byte offsets and upper tag bits carry no information for this block
    assign w_unused_bits = ^{if_addr[OFFS_W-1:0], dm_addr[OFFS_W-1:0],
                             bus_resptag[BUS_TAG_WIDTH-1:8]};

    // Responses are acknowledged only while collecting, so stale beats drop
    assign bus_respack = bus_respcyc && (r_state == ST_RESP);

    // Arbiter FSM with registered grant, done and bus request outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= ID_IF;
            if_gnt     <= 1'b0;
            dm_gnt     <= 1'b0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            bus_reqcyc <= 1'b0;
            bus_req    <= 64'd0;
            bus_reqtag <= '0;
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
            r_last_served <= ID_IF;
`endif
        end else begin
            if_gnt  <= 1'b0;
            dm_gnt  <= 1'b0;
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner    <= w_winner;
                        if_gnt     <= (w_winner == ID_IF);
                        dm_gnt     <= (w_winner == ID_DM);
                        bus_reqcyc <= 1'b1;
                        bus_req    <= w_line_addr;
                        bus_reqtag <= BUS_TAG_WIDTH'({TAG_CMD, 8'(w_winner)});
                        r_state    <= ST_REQ;
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
                        r_last_served <= w_winner;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus_reqack) begin
                        bus_reqcyc <= 1'b0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_RESP: begin
                    if (w_last) begin
                        if_done <= (r_owner == ID_IF);
                        dm_done <= (r_owner == ID_DM);
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    bus_reqcyc <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    sysbus_line_assembler #(
        .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
        .LINE_BEATS     (LINE_BEATS)
    ) u_assembler (
        .clk       (clk),
        .reset     (reset),
        .i_clear   ((r_state == ST_REQ) && bus_reqack),
        .i_active  (r_state == ST_RESP),
        .i_respcyc (bus_respcyc),
        .i_tag_lo  (bus_resptag[7:0]),
        .i_resp    (bus_resp),
        .i_id      (r_owner),
        .o_last    (w_last),
        .o_line    (line_out)
    );

endmodule

// File: tb/tb_sysbus_arbiter.sv
module tb_sysbus_arbiter;

    localparam logic [4:0] EXP_CMD = 5'b01001;

    logic         clk;
    logic         reset;
    logic         if_req, dm_req, if_gnt, dm_gnt, if_done, dm_done;
    logic [63:0]  if_addr, dm_addr, bus_req, bus_resp;
    logic [511:0] line_out;
    logic         bus_reqcyc, bus_respack, bus_reqack, bus_respcyc;
    logic [12:0]  bus_reqtag, bus_resptag;

    int n_pass  = 0;
    int n_total = 0;
    int m_last  = 0;   // model: id served last (0 fetch, 1 dmem)

    logic [63:0]  beat_data [8];
    logic [63:0]  obs_req;
    logic [12:0]  obs_tag;
    logic [511:0] obs_line;
    logic         obs_hold_ok, obs_respack_ok, obs_early_done, obs_extra_gnt;
    logic         obs_done_if, obs_done_dm, obs_done_after, obs_reqcyc_resp;

    sysbus_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_gnt(dm_gnt), .dm_done(dm_done),
        .line_out(line_out),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respack(bus_respack), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec rule: with both raised, RR picks the one not served last, else DM.
    function automatic int exp_winner(input bit p_if, input bit p_dm);
        if (p_if && p_dm) begin
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 1;
`endif
        end
        return p_dm ? 1 : 0;
    endfunction

    function automatic logic [511:0] pack_line();
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = beat_data[i];
        return l;
    endfunction

    task automatic rand_beats();
        for (int i = 0; i < 8; i++) beat_data[i] = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; if_addr = 64'd0; dm_addr = 64'd0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = 64'd0; bus_resptag = 13'd0;
        step();
        step();
        reset = 1'b1;
        m_last = 0;
        step();
    endtask

    task automatic wait_gnt(output int id);
        id = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (if_gnt && dm_gnt) begin id = 2; break; end
            if (dm_gnt) begin id = 1; break; end
            if (if_gnt) begin id = 0; break; end
        end
    endtask

    // Drives the bus side of one transaction already in REQ and records what it sees.
    task automatic serve(input int ack_dly, input int id, input bit inject_bad, input int gap_max);
        int bad_pos;
        int gaps;
        logic [7:0] bad_tag;
        bad_pos = $urandom_range(0, 7);
        obs_req = bus_req;
        obs_tag = bus_reqtag;
        obs_hold_ok = 1'b1; obs_respack_ok = 1'b1;
        obs_early_done = 1'b0; obs_extra_gnt = 1'b0;
        for (int c = 0; c < ack_dly; c++) begin
            if (bus_reqcyc !== 1'b1 || bus_req !== obs_req || bus_reqtag !== obs_tag) obs_hold_ok = 1'b0;
            step();
            if (if_gnt || dm_gnt) obs_extra_gnt = 1'b1;
        end
        if (bus_reqcyc !== 1'b1 || bus_req !== obs_req || bus_reqtag !== obs_tag) obs_hold_ok = 1'b0;
        bus_reqack = 1'b1;
        step();
        bus_reqack = 1'b0;
        obs_reqcyc_resp = bus_reqcyc;
        for (int b = 0; b < 8; b++) begin
            gaps = $urandom_range(0, gap_max);
            repeat (gaps) begin
                bus_respcyc = 1'b0;
                #1;
                if (bus_respack !== 1'b0) obs_respack_ok = 1'b0;
                step();
                if (if_done || dm_done) obs_early_done = 1'b1;
            end
            if (inject_bad && b == bad_pos) begin
                bad_tag = 8'($urandom_range(0, 255));
                if (bad_tag == 8'(id)) bad_tag = bad_tag ^ 8'h02;
                bus_resptag = {5'($urandom_range(0, 31)), bad_tag};
                bus_resp = {$urandom, $urandom};
                bus_respcyc = 1'b1;
                #1;
                if (bus_respack !== 1'b1) obs_respack_ok = 1'b0;
                step();
                if (if_done || dm_done) obs_early_done = 1'b1;
            end
            bus_resptag = {EXP_CMD, 8'(id)};
            bus_resp = beat_data[b];
            bus_respcyc = 1'b1;
            #1;
            if (bus_respack !== 1'b1) obs_respack_ok = 1'b0;
            step();
            if (b < 7 && (if_done || dm_done)) obs_early_done = 1'b1;
            if (if_gnt || dm_gnt) obs_extra_gnt = 1'b1;
        end
        bus_respcyc = 1'b0;
        obs_done_if = if_done;
        obs_done_dm = dm_done;
        obs_line = line_out;
        step();
        obs_done_after = if_done | dm_done;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if_req = 1'b1; dm_req = 1'b1; if_addr = 64'h40; dm_addr = 64'h80;
        bus_reqack = 1'b1; bus_respcyc = 1'b1; bus_resp = 64'hFFFF; bus_resptag = 13'd0;
        step();
        step();
        n_total++; if ({if_gnt, dm_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", {if_gnt, dm_gnt}); else n_pass++;
        n_total++; if ({if_done, dm_done} !== 2'b00) $display("FAIL reset_done: got %b expected 00", {if_done, dm_done}); else n_pass++;
        n_total++; if (bus_reqcyc !== 1'b0) $display("FAIL reset_reqcyc: got %b expected 0", bus_reqcyc); else n_pass++;
        n_total++; if (bus_respack !== 1'b0) $display("FAIL reset_respack: got %b expected 0", bus_respack); else n_pass++;
        n_total++; if (line_out !== 512'd0) $display("FAIL reset_line: got %h expected 0", line_out); else n_pass++;
        do_reset();
    endtask

    task automatic test_basic_fetch();
        int gid;
        if_addr = 64'h1004_0038;
        if_req = 1'b1;
        wait_gnt(gid);
        n_total++; if (gid !== 0) $display("FAIL basic_gnt: got %0d expected 0", gid); else n_pass++;
        if_req = 1'b0;
        if_addr = 64'hDEAD_BEEF_0000_0000;
        m_last = 0;
        for (int i = 0; i < 8; i++) beat_data[i] = 64'(i);
        serve(2, 0, 1'b0, 0);
        n_total++; if (obs_req !== 64'h1004_0000) $display("FAIL basic_addr: got %h expected 1004_0000", obs_req); else n_pass++;
        n_total++; if (obs_tag !== {EXP_CMD, 8'h00}) $display("FAIL basic_tag: got %h expected %h", obs_tag, {EXP_CMD, 8'h00}); else n_pass++;
        n_total++; if ({obs_done_if, obs_done_dm} !== 2'b10) $display("FAIL basic_done: got %b expected 10", {obs_done_if, obs_done_dm}); else n_pass++;
        n_total++; if (obs_line[63:0] !== 64'd0) $display("FAIL basic_beat0: got %h expected 0", obs_line[63:0]); else n_pass++;
        n_total++; if (obs_line[511:448] !== 64'd7) $display("FAIL basic_beat7: got %h expected 7", obs_line[511:448]); else n_pass++;
        n_total++; if (obs_line !== pack_line()) $display("FAIL basic_line: got %h expected %h", obs_line, pack_line()); else n_pass++;
        n_total++; if ({obs_hold_ok, obs_respack_ok, obs_early_done, obs_reqcyc_resp} !== 4'b1100)
            $display("FAIL basic_proto: got hold/ack/early/reqcyc %b expected 1100", {obs_hold_ok, obs_respack_ok, obs_early_done, obs_reqcyc_resp}); else n_pass++;
        n_total++; if (obs_done_after !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", obs_done_after); else n_pass++;
    endtask

    task automatic test_priority();
        int gid;
        do_reset();
        if_addr = 64'h0000_2000_0000_0111; dm_addr = 64'h0000_3000_0000_02C5;
        if_req = 1'b1; dm_req = 1'b1;
        wait_gnt(gid);
        n_total++; if (gid !== 1) $display("FAIL prio_first: got %0d expected 1", gid); else n_pass++;
        dm_req = 1'b0;
        m_last = 1;
        rand_beats();
        serve(1, 1, 1'b0, 1);
        n_total++; if (obs_req !== 64'h0000_3000_0000_02C0) $display("FAIL prio_dm_addr: got %h expected 3000_0000_02C0", obs_req); else n_pass++;
        n_total++; if ({obs_done_if, obs_done_dm, obs_extra_gnt} !== 3'b010) $display("FAIL prio_dm_done: got %b expected 010", {obs_done_if, obs_done_dm, obs_extra_gnt}); else n_pass++;
        wait_gnt(gid);
        n_total++; if (gid !== 0) $display("FAIL prio_second: got %0d expected 0", gid); else n_pass++;
        if_req = 1'b0;
        if (gid < 0) return;
        m_last = 0;
        rand_beats();
        serve(0, 0, 1'b0, 1);
        n_total++; if (obs_req !== 64'h0000_2000_0000_0100) $display("FAIL prio_if_addr: got %h expected 2000_0000_0100", obs_req); else n_pass++;
        n_total++; if ({obs_done_if, obs_done_dm} !== 2'b10) $display("FAIL prio_if_done: got %b expected 10", {obs_done_if, obs_done_dm}); else n_pass++;
        n_total++; if (obs_line !== pack_line()) $display("FAIL prio_if_line: got %h expected %h", obs_line, pack_line()); else n_pass++;
    endtask

    task automatic test_contention();
        int gid;
        int exp_seq [4];
        logic [63:0] cur [2];
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
        exp_seq = '{1, 0, 1, 0};
`else
        exp_seq = '{1, 1, 1, 1};
`endif
        do_reset();
        cur[0] = {$urandom, $urandom}; cur[1] = {$urandom, $urandom};
        if_addr = cur[0]; dm_addr = cur[1];
        if_req = 1'b1; dm_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(gid);
            n_total++; if (gid !== exp_seq[k]) $display("FAIL contend_gnt%0d: got %0d expected %0d", k, gid, exp_seq[k]); else n_pass++;
            if (gid != 0 && gid != 1) begin if_req = 1'b0; dm_req = 1'b0; return; end
            n_total++; if (bus_req !== (cur[gid] & ~64'h3F)) $display("FAIL contend_addr%0d: got %h expected %h", k, bus_req, cur[gid] & ~64'h3F); else n_pass++;
            m_last = gid;
            cur[gid] = {$urandom, $urandom};
            if (gid == 1) dm_addr = cur[1]; else if_addr = cur[0];
            if (k == 3) begin if_req = 1'b0; dm_req = 1'b0; end
            rand_beats();
            serve(0, gid, 1'b0, 0);
        end
    endtask

    task automatic test_tag_mismatch();
        int gid;
        if_addr = 64'h0000_0000_0ABC_0040;
        if_req = 1'b1;
        wait_gnt(gid);
        if_req = 1'b0;
        if (gid == 0) m_last = 0;
        rand_beats();
        serve(1, 0, 1'b1, 0);
        n_total++; if (gid !== 0) $display("FAIL mism_gnt: got %0d expected 0", gid); else n_pass++;
        n_total++; if (obs_line !== pack_line()) $display("FAIL mism_line: got %h expected %h", obs_line, pack_line()); else n_pass++;
        n_total++; if ({obs_respack_ok, obs_early_done, obs_done_if} !== 3'b101)
            $display("FAIL mism_proto: got ack/early/done %b expected 101", {obs_respack_ok, obs_early_done, obs_done_if}); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int gid;
        logic saw_done;
        if_addr = 64'h0000_0000_7777_0000;
        if_req = 1'b1;
        wait_gnt(gid);
        if_req = 1'b0;
        bus_reqack = 1'b1;
        step();
        bus_reqack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus_respcyc = 1'b1; bus_resptag = {EXP_CMD, 8'h00}; bus_resp = 64'h1111 * 64'(b + 1);
            step();
        end
        bus_respcyc = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        m_last = 0;
        n_total++; if ({bus_reqcyc, if_done, dm_done} !== 3'b000) $display("FAIL abort_outputs: got %b expected 000", {bus_reqcyc, if_done, dm_done}); else n_pass++;
        n_total++; if (line_out !== 512'd0) $display("FAIL abort_line: got %h expected 0", line_out); else n_pass++;
        bus_respcyc = 1'b1; bus_resptag = {EXP_CMD, 8'h00}; bus_resp = 64'hBAD0;
        #1;
        n_total++; if (bus_respack !== 1'b0) $display("FAIL abort_stale_ack: got %b expected 0", bus_respack); else n_pass++;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            bus_respcyc = 1'b0;
            if (if_done || dm_done) saw_done = 1'b1;
        end
        n_total++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", saw_done); else n_pass++;
        n_total++; if (line_out !== 512'd0) $display("FAIL abort_stale_line: got %h expected 0", line_out); else n_pass++;
        if_addr = 64'h0000_0000_8888_00FF;
        if_req = 1'b1;
        wait_gnt(gid);
        if_req = 1'b0;
        rand_beats();
        serve(0, 0, 1'b0, 0);
        n_total++; if ({obs_done_if, obs_line === pack_line()} !== 2'b11) $display("FAIL abort_next: got done/line_ok %b expected 11", {obs_done_if, obs_line === pack_line()}); else n_pass++;
    endtask

    task automatic test_reqack_delay();
        int gid;
        dm_addr = 64'hFEDC_BA98_7654_3210;
        dm_req = 1'b1;
        wait_gnt(gid);
        dm_req = 1'b0;
        if (gid == 1) m_last = 1;
        rand_beats();
        serve(10, 1, 1'b0, 0);
        n_total++; if (obs_hold_ok !== 1'b1) $display("FAIL delay_hold: got %b expected 1", obs_hold_ok); else n_pass++;
        n_total++; if (obs_req !== 64'hFEDC_BA98_7654_3200) $display("FAIL delay_addr: got %h expected FEDCBA9876543200", obs_req); else n_pass++;
        n_total++; if (obs_tag !== {EXP_CMD, 8'h01}) $display("FAIL delay_tag: got %h expected %h", obs_tag, {EXP_CMD, 8'h01}); else n_pass++;
        n_total++; if ({obs_done_if, obs_done_dm} !== 2'b01) $display("FAIL delay_done: got %b expected 01", {obs_done_if, obs_done_dm}); else n_pass++;
    endtask

    task automatic test_random();
        int gid, ew, mode;
        bit p_if, p_dm;
        logic [63:0] a_if, a_dm, ea;
        for (int it = 0; it < 16; it++) begin
            mode = $urandom_range(1, 3);
            p_if = mode[0]; p_dm = mode[1];
            a_if = {$urandom, $urandom}; a_dm = {$urandom, $urandom};
            if_addr = a_if; dm_addr = a_dm;
            if_req = p_if; dm_req = p_dm;
            while (p_if || p_dm) begin
                ew = exp_winner(p_if, p_dm);
                wait_gnt(gid);
                n_total++; if (gid !== ew) $display("FAIL rand_gnt it%0d: got %0d expected %0d", it, gid, ew); else n_pass++;
                if (gid != 0 && gid != 1) begin if_req = 1'b0; dm_req = 1'b0; break; end
                m_last = ew;
                if (ew == 1) begin p_dm = 1'b0; dm_req = 1'b0; dm_addr = {$urandom, $urandom}; ea = a_dm; end
                else begin p_if = 1'b0; if_req = 1'b0; if_addr = {$urandom, $urandom}; ea = a_if; end
                rand_beats();
                serve($urandom_range(0, 4), ew, 1'($urandom_range(0, 1)), 2);
                n_total++; if (obs_req !== (ea & ~64'h3F)) $display("FAIL rand_addr it%0d: got %h expected %h", it, obs_req, ea & ~64'h3F); else n_pass++;
                n_total++; if (obs_tag !== {EXP_CMD, 8'(ew)}) $display("FAIL rand_tag it%0d: got %h expected %h", it, obs_tag, {EXP_CMD, 8'(ew)}); else n_pass++;
                n_total++; if ({obs_done_if, obs_done_dm, obs_done_after} !== {ew == 0, ew == 1, 1'b0})
                    $display("FAIL rand_done it%0d: got %b expected %b", it, {obs_done_if, obs_done_dm, obs_done_after}, {ew == 0, ew == 1, 1'b0}); else n_pass++;
                n_total++; if (obs_line !== pack_line()) $display("FAIL rand_line it%0d: got %h expected %h", it, obs_line, pack_line()); else n_pass++;
                n_total++; if ({obs_hold_ok, obs_respack_ok, obs_early_done, obs_extra_gnt} !== 4'b1100)
                    $display("FAIL rand_proto it%0d: got %b expected 1100", it, {obs_hold_ok, obs_respack_ok, obs_early_done, obs_extra_gnt}); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_priority();
        test_contention();
        test_tag_mismatch();
        test_reset_abort();
        test_reqack_delay();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
